// File: rtl/clk_pkg.sv
// Shared constants for the debug clock generator: mode encodings and default widths.
// Imported by clk_div_step and visible to anything that drives its mode input.
package clk_pkg;

   localparam logic [1:0] MODE_HALT  = 2'd0;
   localparam logic [1:0] MODE_RUN   = 2'd1;
   localparam logic [1:0] MODE_STEP  = 2'd2;
   localparam logic [1:0] MODE_BURST = 2'd3;

   localparam int CNT_W_DEF   = 26;
   localparam int BURST_W_DEF = 16;
   localparam int CYC_W_DEF   = 32;
   localparam int DEB_CYC_DEF = 1000000;

endpackage

// File: rtl/step_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability filter and a one-cycle
// pulse on each debounced 0->1 transition.
module step_debounce #(
   parameter int DEB_CYC = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_pulse
);

   localparam int CW = $clog2(DEB_CYC + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          pulse_q, pulse_d;
   logic [CW-1:0] stab_q, stab_d;

   // NOTE: every signal assigned here gets a default first, so no latch is inferred.
   always_comb begin
      level_d = level_q;
      stab_d  = '0;
      // The counter only runs while the synchronized level disagrees with the accepted one.
      if (sync2_q != level_q) begin
         if (stab_q == CW'(DEB_CYC - 1)) begin
            level_d = sync2_q;
         end else begin
            stab_d = stab_q + CW'(1);
         end
      end
      pulse_d = level_d & ~level_q;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         stab_q  <= '0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         pulse_q <= pulse_d;
         stab_q  <= stab_d;
      end
   end

   assign btn_pulse = pulse_q;

endmodule

// File: rtl/clk_div_step.sv
// Programmable CPU clock generator with HALT/RUN/STEP/BURST debug modes.
// mclk is a registered square wave; tick marks the first clk cycle of each high phase.
module clk_div_step
   import clk_pkg::*;
#(
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DEF_DIV = {1'b0, {(CNT_W-1){1'b1}}},
   parameter int               BURST_W = BURST_W_DEF,
   parameter int               DEB_CYC = DEB_CYC_DEF,
   parameter int               CYC_W   = CYC_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic               div_load,
   input  logic [CNT_W-1:0]   div_val,
   input  logic               step_btn,
   input  logic               burst_go,
   input  logic [BURST_W-1:0] burst_n,
   output logic               mclk,
   output logic               tick,
   output logic               busy,
   output logic [CYC_W-1:0]   cyc_cnt
);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   div_q, div_d;
   logic               mclk_q, mclk_d;
   logic               tick_q, tick_d;
   logic [BURST_W-1:0] credit_q, credit_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;

   logic press;
   logic credit_nz;
   logic dbg_mode;
   logic active;
   logic phase_evt;
   logic rise_evt;
   logic fall_evt;

   step_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_step_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (step_btn),
      .btn_pulse (press)
   );

   always_comb begin
      credit_nz = |credit_q;
      dbg_mode  = (mode == MODE_STEP) | (mode == MODE_BURST);
      // A high mclk always keeps the counter running so the half-cycle can finish low.
      active    = mclk_q | (mode == MODE_RUN) | (credit_nz & dbg_mode);
      // A divisor load in the same cycle swallows the phase event.
      phase_evt = active & ~div_load & (cnt_q == div_q);
      rise_evt  = phase_evt & ~mclk_q;
      fall_evt  = phase_evt & mclk_q;

      if (div_load || !active || phase_evt) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      div_d  = div_load ? div_val : div_q;
      mclk_d = mclk_q ^ phase_evt;
      tick_d = rise_evt;
      cyc_d  = cyc_q + {{(CYC_W-1){1'b0}}, rise_evt};

      credit_d = credit_q;
      if (!dbg_mode) begin
         credit_d = '0;
      end else if (credit_nz) begin
         // Requests seen while credit is nonzero are dropped, even on the emptying edge.
         if (fall_evt) credit_d = credit_q - BURST_W'(1);
      end else if (mode == MODE_STEP) begin
         if (press) credit_d = BURST_W'(1);
      end else if (burst_go && (|burst_n)) begin
         credit_d = burst_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         div_q    <= DEF_DIV;
         mclk_q   <= 1'b0;
         tick_q   <= 1'b0;
         credit_q <= '0;
         cyc_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         mclk_q   <= mclk_d;
         tick_q   <= tick_d;
         credit_q <= credit_d;
         cyc_q    <= cyc_d;
      end
   end

   assign mclk    = mclk_q;
   assign tick    = tick_q;
   assign busy    = (|credit_q) | mclk_q;
   assign cyc_cnt = cyc_q;

endmodule

// File: tb/tb_clk_div_step.sv
// Directed bench for clk_div_step with DEF_DIV=3 and DEB_CYC=4; outputs sampled 1 time unit after each edge.
module tb_clk_div_step;
   import clk_pkg::*;

   localparam int CNT_W   = 26;
   localparam int BURST_W = 16;
   localparam int CYC_W   = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         mode;
   logic               div_load;
   logic [CNT_W-1:0]   div_val;
   logic               step_btn;
   logic               burst_go;
   logic [BURST_W-1:0] burst_n;
   logic               mclk;
   logic               tick;
   logic               busy;
   logic [CYC_W-1:0]   cyc_cnt;

   int checks   = 0;
   int failures = 0;

   clk_div_step #(
      .CNT_W   (CNT_W),
      .DEF_DIV (3),
      .BURST_W (BURST_W),
      .DEB_CYC (4),
      .CYC_W   (CYC_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .div_load (div_load),
      .div_val  (div_val),
      .step_btn (step_btn),
      .burst_go (burst_go),
      .burst_n  (burst_n),
      .mclk     (mclk),
      .tick     (tick),
      .busy     (busy),
      .cyc_cnt  (cyc_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] m);
      rst = 1'b1; mode = m; div_load = 1'b0; step_btn = 1'b0; burst_go = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic load_div(input logic [CNT_W-1:0] v);
      div_load = 1'b1; div_val = v;
      cyc();
      div_load = 1'b0;
   endtask

   // Drives step_btn high over [a0,a1) and [b0,b1) of the window; counts ticks and falling edges.
   task automatic watch_btn(input int a0, input int a1, input int b0, input int b1,
                            input int win, output int ticks, output int falls);
      logic prev;
      ticks = 0; falls = 0;
      for (int c = 0; c < win; c++) begin
         step_btn = ((c >= a0) && (c < a1)) || ((c >= b0) && (c < b1));
         prev = mclk;
         cyc();
         if (tick) ticks++;
         if (prev && !mclk) falls++;
      end
      step_btn = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = MODE_RUN; div_load = 1'b0; div_val = '0;
      step_btn = 1'b0; burst_go = 1'b0; burst_n = '0;
      cyc(); cyc();
      checks++;
      if ({mclk, tick, busy} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got mclk/tick/busy=%b want 000", {mclk, tick, busy});
      end
      checks++;
      if (cyc_cnt !== 32'd0) begin
         failures++; $display("FAIL reset_cyc_cnt got %0d want 0", cyc_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_run();
      logic exp_m, exp_t;
      do_reset(MODE_RUN);
      for (int i = 1; i <= 40; i++) begin
         cyc();
         exp_m = (i >= 4) && (((i - 4) % 8) < 4);
         exp_t = (i >= 4) && (((i - 4) % 8) == 0);
         checks++;
         if (mclk !== exp_m || tick !== exp_t) begin
            failures++;
            $display("FAIL run_wave cycle %0d got mclk=%b tick=%b want mclk=%b tick=%b", i, mclk, tick, exp_m, exp_t);
         end
      end
      checks++;
      if (cyc_cnt !== 32'd5) begin
         failures++; $display("FAIL run_cyc_cnt got %0d want 5", cyc_cnt);
      end
   endtask

   task automatic test_div_load();
      do_reset(MODE_RUN);
      repeat (5) cyc();
      checks++;
      if (mclk !== 1'b1) begin
         failures++; $display("FAIL divload_pre got mclk=%b want 1", mclk);
      end
      load_div('0);
      checks++;
      if (mclk !== 1'b1 || tick !== 1'b0) begin
         failures++; $display("FAIL divload_edge got mclk=%b tick=%b want 1 0", mclk, tick);
      end
      for (int k = 1; k <= 8; k++) begin
         cyc();
         checks++;
         if (mclk !== (k % 2 == 0) || tick !== (k % 2 == 0)) begin
            failures++;
            $display("FAIL divload_fast cycle %0d got mclk=%b tick=%b want %0d", k, mclk, tick, (k % 2 == 0));
         end
      end
   endtask

   task automatic test_step();
      int ticks, falls;
      do_reset(MODE_STEP);
      load_div(1);
      watch_btn(0, 2, 0, 0, 20, ticks, falls);
      checks++;
      if (ticks !== 0 || mclk !== 1'b0) begin
         failures++; $display("FAIL step_glitch got ticks=%0d mclk=%b want 0 0", ticks, mclk);
      end
      watch_btn(0, 10, 0, 0, 30, ticks, falls);
      checks++;
      if (ticks !== 1 || falls !== 1) begin
         failures++; $display("FAIL step_press got ticks=%0d falls=%0d want 1 1", ticks, falls);
      end
      checks++;
      if (busy !== 1'b0 || mclk !== 1'b0 || cyc_cnt !== 32'd1) begin
         failures++; $display("FAIL step_idle got busy=%b mclk=%b cyc=%0d want 0 0 1", busy, mclk, cyc_cnt);
      end
      load_div(15);
      watch_btn(0, 10, 18, 28, 80, ticks, falls);
      checks++;
      if (ticks !== 1 || falls !== 1) begin
         failures++; $display("FAIL step_busy_press got ticks=%0d falls=%0d want 1 1", ticks, falls);
      end
      checks++;
      if (busy !== 1'b0 || cyc_cnt !== 32'd2) begin
         failures++; $display("FAIL step_busy_idle got busy=%b cyc=%0d want 0 2", busy, cyc_cnt);
      end
   endtask

   task automatic test_burst();
      int ticks, last_busy, busy_seen;
      do_reset(MODE_BURST);
      load_div(0);
      burst_n = '0; burst_go = 1'b1;
      cyc();
      burst_go = 1'b0;
      ticks = 0; busy_seen = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (tick) ticks++;
         if (busy) busy_seen++;
      end
      checks++;
      if (ticks !== 0 || busy_seen !== 0) begin
         failures++; $display("FAIL burst_zero got ticks=%0d busy_cycles=%0d want 0 0", ticks, busy_seen);
      end
      burst_n = 16'd3; burst_go = 1'b1;
      ticks = 0; last_busy = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (i == 1) burst_go = 1'b0;
         if (i == 3) burst_go = 1'b1;
         if (i == 4) burst_go = 1'b0;
         if (tick) ticks++;
         if (busy) last_busy = i;
      end
      checks++;
      if (ticks !== 3 || cyc_cnt !== 32'd3) begin
         failures++; $display("FAIL burst_ticks got ticks=%0d cyc=%0d want 3 3", ticks, cyc_cnt);
      end
      checks++;
      if (last_busy !== 6 || mclk !== 1'b0) begin
         failures++; $display("FAIL burst_busy_end got last_busy=%0d mclk=%b want 6 0", last_busy, mclk);
      end
   endtask

   task automatic test_halt();
      int ticks;
      do_reset(MODE_RUN);
      repeat (5) cyc();
      mode = MODE_HALT;
      cyc(); cyc();
      checks++;
      if (mclk !== 1'b1) begin
         failures++; $display("FAIL halt_finish_high got mclk=%b want 1", mclk);
      end
      cyc();
      checks++;
      if (mclk !== 1'b0) begin
         failures++; $display("FAIL halt_fall got mclk=%b want 0", mclk);
      end
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (tick || mclk) ticks++;
      end
      checks++;
      if (ticks !== 0 || cyc_cnt !== 32'd1) begin
         failures++; $display("FAIL halt_hold got activity=%0d cyc=%0d want 0 1", ticks, cyc_cnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      int ticks;
      do_reset(MODE_BURST);
      load_div(7);
      burst_n = 16'd3; burst_go = 1'b1;
      cyc();
      burst_go = 1'b0;
      repeat (24) cyc();
      checks++;
      if (mclk !== 1'b1 || busy !== 1'b1 || cyc_cnt !== 32'd2) begin
         failures++; $display("FAIL midburst_pre got mclk=%b busy=%b cyc=%0d want 1 1 2", mclk, busy, cyc_cnt);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if ({mclk, tick, busy} !== 3'b000 || cyc_cnt !== 32'd0) begin
         failures++; $display("FAIL midburst_reset got mclk/tick/busy=%b cyc=%0d want 000 0", {mclk, tick, busy}, cyc_cnt);
      end
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (tick || busy) ticks++;
      end
      checks++;
      if (ticks !== 0) begin
         failures++; $display("FAIL midburst_credit_cleared got activity=%0d want 0", ticks);
      end
      mode = MODE_RUN;
      repeat (3) cyc();
      checks++;
      if (mclk !== 1'b0) begin
         failures++; $display("FAIL midburst_defdiv_early got mclk=%b want 0", mclk);
      end
      cyc();
      checks++;
      if (mclk !== 1'b1 || tick !== 1'b1) begin
         failures++; $display("FAIL midburst_defdiv_rise got mclk=%b tick=%b want 1 1", mclk, tick);
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_div_load();
      test_step();
      test_burst();
      test_halt();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
